// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: sequencing FSM for the Goldschmidt fpdiv datapath (load, ITERS refinement passes,
// remainder pass, round, hold result until taken).
module fpdiv_ctrl #(
    parameter int ITERS   = 3,
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] rnd_mode,
    input  logic       special,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ld_op,
    output logic       init_sel,
    output logic       mul_go,
    output logic       rem_sel,
    output logic       cap_iter,
    output logic       cap_rem,
    output logic       en_q,
    output logic [1:0] rm_q,
    output logic       busy
);
    localparam int PW = ITERS > 1 ? $clog2(ITERS + 1) : 1;
    localparam int HW = MUL_LAT > 1 ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(ITERS);
    localparam logic [HW-1:0] H_LAST = HW'(MUL_LAT);
    typedef enum logic [2:0] {IDLE, LOAD, PASS, ROUND, DONE} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [HW-1:0] ph_q, ph_d;
    logic first_go;
    // LOAD doubles as phase 0 of the first pass, so PASS is entered at phase 1
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        ph_d    = ph_q;
        unique case (state_q)
            IDLE:  state_d = in_valid ? LOAD : IDLE;
            LOAD: begin
                state_d = special ? DONE : PASS;
                pass_d  = '0;
                ph_d    = special ? '0 : HW'(1);
            end
            PASS: begin
                ph_d    = ph_q == H_LAST ? '0 : ph_q + 1'b1;
                pass_d  = ph_q != H_LAST ? pass_q : pass_q == P_LAST ? '0 : pass_q + 1'b1;
                state_d = (ph_q == H_LAST && pass_q == P_LAST) ? ROUND : PASS;
            end
            ROUND: state_d = DONE;
            DONE:  state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= '0;
            ph_q    <= '0;
            rm_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            ph_q    <= ph_d;
            if (state_q == IDLE && in_valid) rm_q <= rnd_mode;
        end
    end
    assign first_go  = state_q == LOAD && !special;
    assign in_ready  = state_q == IDLE && !reset;
    assign busy      = state_q != IDLE;
    assign ld_op     = state_q == LOAD;
    assign mul_go    = first_go || (state_q == PASS && ph_q == '0);
    assign init_sel  = first_go || (state_q == PASS && pass_q == '0);
    assign rem_sel   = state_q == PASS && pass_q == P_LAST;
    assign cap_iter  = state_q == PASS && ph_q == H_LAST && pass_q != P_LAST;
    assign cap_rem   = state_q == PASS && ph_q == H_LAST && pass_q == P_LAST;
    assign en_q      = state_q == ROUND;
    assign out_valid = state_q == DONE;
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: directed checks of pulse timing, special path, backpressure and reset for two
// parameterisations driven from shared stimulus.
module tb_fpdiv_ctrl;
    logic clk = 0, reset = 1, in_valid = 0, special = 0, out_ready = 0;
    logic [1:0] rnd_mode = 0, rm_exp = 0;
    logic a_ir, a_ov, a_ld, a_is, a_mg, a_rs, a_ci, a_cr, a_eq, a_bz;
    logic b_ir, b_ov, b_ld, b_is, b_mg, b_rs, b_ci, b_cr, b_eq, b_bz;
    logic [1:0] a_rm, b_rm;
    logic [63:0] v_mg, v_ci, v_cr, v_eq, v_ld, v_ov, v_is, v_rs, v_bz, v_ir;
    logic [63:0] w_mg, w_ci, w_cr, w_eq, w_ov;
    int rm_bad, errors = 0, checks = 0;
    always #5 clk = ~clk;
    fpdiv_ctrl u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ir), .rnd_mode(rnd_mode),
        .special(special), .out_valid(a_ov), .out_ready(out_ready), .ld_op(a_ld), .init_sel(a_is),
        .mul_go(a_mg), .rem_sel(a_rs), .cap_iter(a_ci), .cap_rem(a_cr), .en_q(a_eq), .rm_q(a_rm),
        .busy(a_bz)
    );
    fpdiv_ctrl #(.ITERS(1), .MUL_LAT(1)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ir), .rnd_mode(rnd_mode),
        .special(special), .out_valid(b_ov), .out_ready(out_ready), .ld_op(b_ld), .init_sel(b_is),
        .mul_go(b_mg), .rem_sel(b_rs), .cap_iter(b_ci), .cap_rem(b_cr), .en_q(b_eq), .rm_q(b_rm),
        .busy(b_bz)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Bit k of each vector records the output in cycle k after the accepting edge.
    task automatic cap(input int n, input bit hold);
        {v_mg, v_ci, v_cr, v_eq, v_ld, v_ov, v_is, v_rs, v_bz, v_ir} = '0;
        {w_mg, w_ci, w_cr, w_eq, w_ov} = '0;
        rm_bad = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (!hold) in_valid = 0;
            rnd_mode = ~rm_exp;
            #1;
            v_mg[k] = a_mg; v_ci[k] = a_ci; v_cr[k] = a_cr; v_eq[k] = a_eq; v_ld[k] = a_ld;
            v_ov[k] = a_ov; v_is[k] = a_is; v_rs[k] = a_rs; v_bz[k] = a_bz; v_ir[k] = a_ir;
            w_mg[k] = b_mg; w_ci[k] = b_ci; w_cr[k] = b_cr; w_eq[k] = b_eq; w_ov[k] = b_ov;
            if (a_rm !== rm_exp || b_rm !== rm_exp) rm_bad++;
        end
    endtask
    task automatic take();
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #2;
        check("take_in_ready", {62'd0, a_ir, b_ir}, 64'h3);
        check("take_out_valid", {62'd0, a_ov, b_ov}, 64'h0);
        out_ready = 0;
    endtask
    initial begin
        repeat (10) @(posedge clk);
        #1;
        check("reset_a", {a_ir, a_ov, a_ld, a_is, a_mg, a_rs, a_ci, a_cr, a_eq, a_bz, a_rm}, 0);
        check("reset_b", {b_ir, b_ov, b_ld, b_is, b_mg, b_rs, b_ci, b_cr, b_eq, b_bz, b_rm}, 0);
        reset = 0;
        @(posedge clk);
        #1;
        check("release_in_ready", {62'd0, a_ir, b_ir}, 64'h3);
        // normal op, rnd_mode 11, in_valid held high while busy, 20+ cycles of backpressure
        rm_exp = 2'b11; rnd_mode = 2'b11; in_valid = 1;
        cap(34, 1);
        check("norm_ld_op", v_ld, 64'h2);
        check("norm_mul_go", v_mg, 64'h492);
        check("norm_cap_iter", v_ci, 64'h248);
        check("norm_cap_rem", v_cr, 64'h1000);
        check("norm_en_q", v_eq, 64'h2000);
        check("norm_init_sel", v_is, 64'hE);
        check("norm_rem_sel", v_rs, 64'h1C00);
        check("norm_out_valid", v_ov, 64'h7_FFFF_C000);
        check("norm_busy", v_bz, 64'h7_FFFF_FFFE);
        check("norm_in_ready", v_ir, 64'h0);
        check("norm_rm_stable", 64'(rm_bad), 64'h0);
        check("b_mul_go", w_mg, 64'hA);
        check("b_cap_iter", w_ci, 64'h4);
        check("b_cap_rem", w_cr, 64'h10);
        check("b_en_q", w_eq, 64'h20);
        check("b_out_valid", w_ov, 64'h7_FFFF_FFC0);
        take();
        // special operand path
        rm_exp = 2'b10; rnd_mode = 2'b10; special = 1; in_valid = 1;
        cap(6, 0);
        check("spec_ld_op", v_ld, 64'h2);
        check("spec_mul_go", v_mg | w_mg, 64'h0);
        check("spec_caps", v_ci | v_cr | w_ci | w_cr, 64'h0);
        check("spec_en_q", v_eq | w_eq, 64'h0);
        check("spec_init_sel", v_is, 64'h0);
        check("spec_out_valid", v_ov, 64'h7C);
        check("spec_b_out_valid", w_ov, 64'h7C);
        check("spec_rm_stable", 64'(rm_bad), 64'h0);
        special = 0;
        take();
        // asynchronous reset in cycle T0+6
        rm_exp = 2'b01; rnd_mode = 2'b01; in_valid = 1;
        cap(5, 0);
        @(posedge clk);
        #1;
        reset = 1;
        #1;
        check("midrst_a", {a_ir, a_ov, a_ld, a_is, a_mg, a_rs, a_ci, a_cr, a_eq, a_bz, a_rm}, 0);
        check("midrst_b", {b_ir, b_ov, b_bz, b_rm}, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", {62'd0, a_ir, b_ir}, 64'h3);
        rm_exp = 2'b00; rnd_mode = 2'b00; in_valid = 1;
        cap(16, 0);
        check("rerun_mul_go", v_mg, 64'h492);
        check("rerun_out_valid", v_ov, 64'h1C000);
        check("rerun_b_out_valid", w_ov, 64'h1FFC0);
        take();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
